load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly upstream of the data memory, between the execute/memory pipeline stage and the byte-lane RAM.
- Turns typed load/store requests (byte, halfword, word; signed or unsigned loads) into raw memory cycles: write enable, byte enable, lane-replicated write data, and a read address.
- For loads, extracts and sign- or zero-extends the addressed lanes of the returned word.
- The memory supports only single-byte or full-word enables, so halfword stores run as two sequenced byte writes; the block stalls the pipeline for that extra cycle.

Parameters:
- ADDR_W, 32, width of request and memory address.
- ERR_ZERO_DATA, 1, when 1, resp_rdata is forced to 0 on an error response.

Ports:
- clk  in  1  system clock; the memory writes on the falling edge of clk.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_err  out  1  qualified by resp_valid: misaligned or illegal request.
- resp_rdata  out  32  extended load data, qualified by resp_valid.
- mem_we  out  1  to memory WE.
- mem_be  out  4  to memory BE.
- mem_addr  out  ADDR_W  to memory A.
- mem_wd  out  32  to memory WD.
- mem_rd  in  32  from memory RD; asynchronous read.

Behaviour:
- States: IDLE and HALF2.
  - req_ready = 1 only in IDLE.
  - A request is accepted when req_valid && req_ready.
- Reset:
  - State goes to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_we all 0.
  - mem_be = 4'b0000 (not 4'b1111, which the memory treats as a full-word write).
  - Outputs change immediately on rst assertion, without waiting for a clock edge.
- Error check, evaluated in the accept cycle:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
  - On error: mem_we = 0, no read used, state stays IDLE.
  - Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0 if ERR_ZERO_DATA.
- Memory outputs in IDLE are combinational from the request, and are driven only while req_valid. Otherwise mem_we = 0 and mem_be = 0.
- mem_addr = req_addr unmodified; the memory divides the address by 4.
- Byte store: mem_we = 1, mem_be = 1 << addr[1:0], mem_wd = {4{wdata[7:0]}}. Stays IDLE; resp_valid the next cycle.
- Word store: mem_we = 1, mem_be = 4'b1111, mem_wd = wdata. Stays IDLE; resp_valid the next cycle.
- Halfword store, accept cycle:
  - Writes the low lane: be = 1 << addr[1:0], wd = {4{wdata[7:0]}}.
  - Latches addr and wdata[15:8]; goes to HALF2.
- Halfword store, HALF2 cycle:
  - mem_we = 1, be = 1 << (addr[1:0]+1), wd = {4{latched byte}}, mem_addr = latched addr.
  - Returns to IDLE; resp_valid the following cycle.
  - Latency is 2 cycles from accept to resp_valid.
- Loads (latency 1): in the accept cycle mem_we = 0 and mem_addr = req_addr. Extracted data is registered into resp_rdata, with resp_valid next cycle.
  - Byte load: lane = mem_rd[8*addr[1:0] +: 8], extended to 32 bits per req_unsigned.
  - Halfword load: lanes addr[1]?[31:16]:[15:0], extended.
  - Word load: mem_rd unchanged.
- resp_valid is high for exactly one cycle per accepted request. resp_err is 0 unless set by the error check.
- Back-to-back requests:
  - Accepted every cycle in IDLE.
  - A new request may be accepted in the same cycle that resp_valid of the previous one is high.
- Reset during HALF2: the second byte is never written, no response is issued, and the state returns to IDLE.
- req_valid is ignored in HALF2; the requester must hold its request until req_ready.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → mem_be = 1111; load resp_rdata = 0xDEADBEEF one cycle after accept; resp_err = 0.
- sb addr 0x13 data 0x000000A5, then lb 0x13 and lbu 0x13 → mem_be = 1000 and mem_wd = 0xA5A5A5A5; lb returns 0xFFFFFFA5, lbu returns 0x000000A5.
- sh addr 0x22 data 0x00008001 → accept cycle be = 0100, wd = 0x01010101; HALF2 be = 1000, wd = 0x80808080; req_ready = 0 for one cycle; resp_valid 2 cycles after accept; lh 0x22 returns 0xFFFF8001, lhu 0x22 returns 0x00008001.
- lw 0x21, sh 0x23, and size=11 → no mem_we; resp_valid with resp_err = 1 and resp_rdata = 0; memory contents unchanged.
- sh 0x30 data 0xBBAA over word 0x11223344, with rst pulsed during HALF2 → only the low byte is written (word reads 0x112233AA); no resp_valid; req_ready = 1 immediately after rst.
- Negative address: sw addr 0xFFFFFFFC data 0x12345678, then lw 0xFFFFFFFC → returns 0x12345678.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store front end for a byte-lane RAM: builds write enables and lane-replicated
// write data, splits halfword stores into two byte writes, and extends load data.
module load_store_unit #(
    parameter int ADDR_W        = 32,
    parameter bit ERR_ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] HALF2 = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_byte;
    logic              accept, err, half_store;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign err        = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign half_store = req_we && (req_size == 2'b01) && !err;

    always_comb begin
        ld_byte = mem_rd[7:0];
        case (req_addr[1:0])
            2'd0: ld_byte = mem_rd[7:0];
            2'd1: ld_byte = mem_rd[15:8];
            2'd2: ld_byte = mem_rd[23:16];
            2'd3: ld_byte = mem_rd[31:24];
            default: ld_byte = mem_rd[7:0];
        endcase
        ld_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (req_size)
            2'b00:   load_data = {{24{ld_byte[7] & ~req_unsigned}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~req_unsigned}}, ld_half};
            default: load_data = mem_rd;
        endcase
    end

    // Memory strobes are gated by rst so a reset mid-halfword blocks the second write.
    always_comb begin
        mem_we   = 1'b0;
        mem_be   = 4'b0000;
        mem_addr = req_addr;
        mem_wd   = 32'd0;
        if (rst) begin
            mem_we = 1'b0;
        end else if (state == HALF2) begin
            mem_we   = 1'b1;
            mem_be   = 4'b0001 << (h_addr[1:0] + 2'd1);
            mem_wd   = {4{h_byte}};
            mem_addr = h_addr;
        end else if (req_valid && req_we && !err) begin
            mem_we = 1'b1;
            if (req_size == 2'b10) begin
                mem_be = 4'b1111;
                mem_wd = req_wdata;
            end else begin
                mem_be = 4'b0001 << req_addr[1:0];
                mem_wd = {4{req_wdata[7:0]}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            h_addr     <= '0;
            h_byte     <= 8'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= ERR_ZERO_DATA ? 32'd0 : load_data;
                        end else if (half_store) begin
                            state  <= HALF2;
                            h_addr <= req_addr;
                            h_byte <= req_wdata[15:8];
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= req_we ? 32'd0 : load_data;
                        end
                    end
                end
                HALF2: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
